// File: rtl/bist_alu_unit_pkg.sv
// Shared types, opcodes and pure helpers for the ALU BIST slice.
// The LFSR step, bit-swap and ALU are functions so the golden image and the datapath agree.
package bist_pkg;

   localparam int DATA_W = 8;
   localparam int RESP_W = 9;

   // Feedback taps for x^8+x^6+x^5+x^4+1 in a left-shifting Fibonacci register
   localparam logic [DATA_W-1:0] LFSR_TAPS = 8'b1011_1000;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_MUL  = 4'h2;
   localparam logic [3:0] OP_DIV  = 4'h3;
   localparam logic [3:0] OP_SHL  = 4'h4;
   localparam logic [3:0] OP_SHR  = 4'h5;
   localparam logic [3:0] OP_ROL  = 4'h6;
   localparam logic [3:0] OP_ROR  = 4'h7;
   localparam logic [3:0] OP_AND  = 4'h8;
   localparam logic [3:0] OP_OR   = 4'h9;
   localparam logic [3:0] OP_XOR  = 4'hA;
   localparam logic [3:0] OP_NOR  = 4'hB;
   localparam logic [3:0] OP_NAND = 4'hC;
   localparam logic [3:0] OP_XNOR = 4'hD;
   localparam logic [3:0] OP_GT   = 4'hE;
   localparam logic [3:0] OP_EQ   = 4'hF;

   typedef struct packed {
      logic [DATA_W-1:0] res;
      logic              carry;
   } resp_t;

   function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] s);
      return {s[6:0], ^(s & LFSR_TAPS)};
   endfunction

   function automatic logic [DATA_W-1:0] bit_swap(input logic [DATA_W-1:0] s);
      return s[7] ? {s[7], s[5], s[6], s[3], s[4], s[1], s[2], s[0]} : s;
   endfunction

   function automatic logic [DATA_W-1:0] alu_fn(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b,
                                                input logic [3:0]        op);
      logic [DATA_W-1:0] r;
      r = '0;
      case (op)
         OP_ADD:  r = a + b;
         OP_SUB:  r = a - b;
         OP_MUL:  r = a * b;
         OP_DIV:  r = (b == '0) ? 8'hFF : a / b;
         OP_SHL:  r = {a[6:0], 1'b0};
         OP_SHR:  r = {1'b0, a[7:1]};
         OP_ROL:  r = {a[6:0], a[7]};
         OP_ROR:  r = {a[0], a[7:1]};
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_XOR:  r = a ^ b;
         OP_NOR:  r = ~(a | b);
         OP_NAND: r = ~(a & b);
         OP_XNOR: r = ~(a ^ b);
         OP_GT:   r = (a > b) ? 8'h01 : 8'h00;
         OP_EQ:   r = (a == b) ? 8'h01 : 8'h00;
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic logic alu_carry(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
      logic [DATA_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[DATA_W];
   endfunction

endpackage

// File: rtl/bist_alu_unit_if.sv
// Observation bus of the BIST block: operands, opcode, ALU response, golden word and status.
interface bist_alu_unit_if;
   import bist_pkg::*;

   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;
   logic [3:0]        alu_sel;
   logic [DATA_W-1:0] alu_out;
   logic              carry_out;
   logic [7:0]        address;
   logic [RESP_W-1:0] rom_data;
   logic              match;
   logic [8:0]        fail_count;
   logic              error;
   logic              done;

   modport master (output a, b, alu_sel, alu_out, carry_out, address, rom_data,
                          match, fail_count, error, done);
   modport slave  (input  a, b, alu_sel, alu_out, carry_out, address, rom_data,
                          match, fail_count, error, done);
endinterface

// File: rtl/bist_alu_unit_lfsr.sv
// Bit-swapping 8-bit LFSR: Fibonacci register whose output pairs swap when the MSB is set.
module bs_lfsr8
   import bist_pkg::*;
#(
   parameter logic [DATA_W-1:0] SEED = 8'h01
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en_i,
   output logic [DATA_W-1:0] out_o
);

   logic [DATA_W-1:0] s_q, s_d;

   assign s_d = en_i ? lfsr_next(s_q) : s_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) s_q <= SEED;
      else       s_q <= s_d;
   end

   assign out_o = bit_swap(s_q);

endmodule

// File: rtl/bist_alu_unit.sv
// BIST for an 8-bit 16-function ALU: two BS-LFSRs drive operands, responses are checked against
// a golden image built at elaboration from the same LFSR/ALU rules (FAULT_* corrupts one word).
module bist_alu_unit
   import bist_pkg::*;
#(
   parameter logic [DATA_W-1:0] SEED_A      = 8'h01,
   parameter logic [DATA_W-1:0] SEED_B      = 8'hFF,
   parameter int                NUM_VECTORS = 256,
   parameter int                FAULT_ADDR  = 0,
   parameter logic [RESP_W-1:0] FAULT_MASK  = '0
) (
   input  logic             clk,
   input  logic             reset,
   bist_alu_unit_if.master  bus_o
);

   localparam logic [7:0] LAST = 8'(NUM_VECTORS - 1);

   typedef logic [NUM_VECTORS*RESP_W-1:0] rom_img_t;

   function automatic rom_img_t build_rom();
      rom_img_t          img;
      logic [DATA_W-1:0] sa, sb, va, vb;
      img = '0;
      sa  = SEED_A;
      sb  = SEED_B;
      for (int n = 0; n < NUM_VECTORS; n++) begin
         va = bit_swap(sa);
         vb = bit_swap(sb);
         img[n*RESP_W +: RESP_W] = {alu_fn(va, vb, 4'(n)), alu_carry(va, vb)};
         if (n == FAULT_ADDR) img[n*RESP_W +: RESP_W] ^= FAULT_MASK;
         sa = lfsr_next(sa);
         sb = lfsr_next(sb);
      end
      return img;
   endfunction

   localparam rom_img_t ROM_IMG = build_rom();

   logic [DATA_W-1:0] a, b, alu_out;
   logic              carry_out, match, adv;
   resp_t             resp, rom_data;

   logic [3:0] alu_sel_q, alu_sel_d;
   logic [7:0] address_q, address_d;
   logic [8:0] fail_q, fail_d;
   logic       error_q, error_d;
   logic       done_q, done_d;

   // The last vector holds its operands so the frozen outputs still describe vector LAST
   assign adv = !done_q && (address_q != LAST);

   bs_lfsr8 #(.SEED(SEED_A)) u_lfsr_a (.clk(clk), .reset(reset), .en_i(adv), .out_o(a));
   bs_lfsr8 #(.SEED(SEED_B)) u_lfsr_b (.clk(clk), .reset(reset), .en_i(adv), .out_o(b));

   always_comb begin
      alu_out   = alu_fn(a, b, alu_sel_q);
      carry_out = alu_carry(a, b);
   end

   assign rom_data = ROM_IMG[32'(address_q)*RESP_W +: RESP_W];
   assign resp     = '{res: alu_out, carry: carry_out};
   assign match    = (resp == rom_data);

   always_comb begin
      alu_sel_d = alu_sel_q;
      address_d = address_q;
      fail_d    = fail_q;
      error_d   = error_q;
      done_d    = done_q;
      if (!done_q) begin
         if (address_q == LAST) begin
            done_d = 1'b1;
         end else begin
            alu_sel_d = alu_sel_q + 4'd1;
            address_d = address_q + 8'd1;
         end
         if (!match) begin
            error_d = 1'b1;
            if (fail_q != '1) fail_d = fail_q + 9'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         alu_sel_q <= '0;
         address_q <= '0;
         fail_q    <= '0;
         error_q   <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         alu_sel_q <= alu_sel_d;
         address_q <= address_d;
         fail_q    <= fail_d;
         error_q   <= error_d;
         done_q    <= done_d;
      end
   end

   assign bus_o.a          = a;
   assign bus_o.b          = b;
   assign bus_o.alu_sel    = alu_sel_q;
   assign bus_o.alu_out    = alu_out;
   assign bus_o.carry_out  = carry_out;
   assign bus_o.address    = address_q;
   assign bus_o.rom_data   = rom_data;
   assign bus_o.match      = match;
   assign bus_o.fail_count = fail_q;
   assign bus_o.error      = error_q;
   assign bus_o.done       = done_q;

endmodule

// File: tb/tb_bist_alu_unit.sv
// Bench: a clean BIST instance and one with golden word 5 bit 0 flipped, checked against an
// arithmetic model of the operand sequence and ALU, with fixed and random mid-run resets.
module tb_bist_alu_unit;
   import bist_pkg::*;

   logic clk, reset;
   int   n_chk, n_pass;

   bist_alu_unit_if if_g ();
   bist_alu_unit_if if_f ();

   bist_alu_unit #(.SEED_A(8'h01), .SEED_B(8'hFF), .NUM_VECTORS(256))
      dut_g (.clk(clk), .reset(reset), .bus_o(if_g));

   bist_alu_unit #(.SEED_A(8'h01), .SEED_B(8'hFF), .NUM_VECTORS(256),
                   .FAULT_ADDR(5), .FAULT_MASK(9'h001))
      dut_f (.clk(clk), .reset(reset), .bus_o(if_f));

   always #5 clk = ~clk;

   logic [7:0] ma [256];
   logic [7:0] mb [256];

   typedef struct { logic [7:0] a, b; logic [3:0] op; logic [7:0] r; } at_t;
   typedef struct { int n; logic [7:0] a, b; logic [3:0] sel; logic [7:0] alu; logic c; } sv_t;
   at_t alu_tab [15];
   sv_t spec_tab [2];

   function automatic logic [7:0] m_step(input logic [7:0] s);
      int v, fb;
      v  = int'(s);
      fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
      return 8'(((v << 1) | fb) & 255);
   endfunction

   function automatic logic [7:0] m_swap(input logic [7:0] s);
      if (s >= 8'h80) return (s & 8'h81) | ((s & 8'h54) >> 1) | ((s & 8'h2A) << 1);
      return s;
   endfunction

   function automatic logic [7:0] m_alu(input int a, input int b, input int op);
      int r;
      case (op)
         0:  r = (a + b) % 256;
         1:  r = (a - b + 256) % 256;
         2:  r = (a * b) % 256;
         3:  r = (b == 0) ? 255 : a / b;
         4:  r = (a * 2) % 256;
         5:  r = a / 2;
         6:  r = ((a * 2) % 256) + a / 128;
         7:  r = a / 2 + (a % 2) * 128;
         8:  r = a & b;
         9:  r = a | b;
         10: r = a ^ b;
         11: r = 255 - (a | b);
         12: r = 255 - (a & b);
         13: r = 255 - (a ^ b);
         14: r = (a > b) ? 1 : 0;
         default: r = (a == b) ? 1 : 0;
      endcase
      return 8'(r);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", name, act, exp);
   endtask

   task automatic check_reset(input string tag);
      check({tag, " reset state"},
            {if_g.a, if_g.b, if_g.alu_sel, if_g.address, if_g.alu_out, if_g.carry_out},
            {8'h01, 8'hFF, 4'h0, 8'h00, 8'h00, 1'b1});
      check({tag, " reset status"},
            {if_g.fail_count, if_g.error, if_g.done, if_f.fail_count, if_f.error, if_f.done, if_f.address},
            {9'd0, 1'b0, 1'b0, 9'd0, 1'b0, 1'b0, 8'h00});
   endtask

   task automatic check_vec(input int n, input string tag);
      logic [7:0] ea;
      logic       ec;
      ea = m_alu(int'(ma[n]), int'(mb[n]), n % 16);
      ec = (int'(ma[n]) + int'(mb[n])) > 255;
      check($sformatf("%s v%0d state", tag, n),
            {if_g.a, if_g.b, if_g.alu_sel, if_g.address},
            {ma[n], mb[n], 4'(n % 16), 8'(n)});
      check($sformatf("%s v%0d resp", tag, n),
            {if_g.alu_out, if_g.carry_out, if_g.match, if_g.rom_data, if_g.done, if_g.error, if_g.fail_count},
            {ea, ec, 1'b1, ea, ec, 1'b0, 1'b0, 9'd0});
      check($sformatf("%s v%0d faulty", tag, n),
            {if_f.alu_out, if_f.match, if_f.rom_data, if_f.error, if_f.fail_count, if_f.done},
            {ea, 1'(n != 5), {ea, ec} ^ 9'(n == 5), 1'(n > 5), 9'(n > 5), 1'b0});
      foreach (spec_tab[i])
         if (spec_tab[i].n == n)
            check($sformatf("%s spec v%0d", tag, n),
                  {if_g.a, if_g.b, if_g.alu_sel, if_g.address, if_g.alu_out, if_g.carry_out},
                  {spec_tab[i].a, spec_tab[i].b, spec_tab[i].sel, 8'(n), spec_tab[i].alu, spec_tab[i].c});
   endtask

   // Entered just after reset release; abort_at < 0 runs to completion
   task automatic run(input int abort_at, input string tag);
      for (int n = 0; n < 256; n++) begin
         check_vec(n, tag);
         if (n == abort_at) begin
            #2 reset = 1'b1;
            #1 check_reset({tag, " abort"});
            repeat ($urandom_range(1, 3)) @(negedge clk);
            reset = 1'b0;
            #1;
            return;
         end
         @(negedge clk);
      end
      #1;
      check({tag, " done golden"},
            {if_g.done, if_g.error, if_g.fail_count, if_g.address, if_g.a, if_g.b, if_g.alu_sel},
            {1'b1, 1'b0, 9'd0, 8'hFF, ma[255], mb[255], 4'hF});
      check({tag, " done faulty"},
            {if_f.done, if_f.error, if_f.fail_count, if_f.address},
            {1'b1, 1'b1, 9'd1, 8'hFF});
      repeat (4) @(negedge clk);
      #1;
      check({tag, " frozen"},
            {if_g.done, if_g.match, if_g.address, if_g.a, if_g.b, if_f.fail_count, if_f.error},
            {1'b1, 1'b1, 8'hFF, ma[255], mb[255], 9'd1, 1'b1});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] sa, sb;
      n_chk = 0;
      n_pass = 0;
      clk = 1'b0;
      reset = 1'b1;

      sa = 8'h01;
      sb = 8'hFF;
      for (int n = 0; n < 256; n++) begin
         ma[n] = m_swap(sa);
         mb[n] = m_swap(sb);
         sa = m_step(sa);
         sb = m_step(sb);
      end

      spec_tab[0] = '{0, 8'h01, 8'hFF, 4'h0, 8'h00, 1'b1};
      spec_tab[1] = '{1, 8'h02, 8'hFE, 4'h1, 8'h04, 1'b1};

      alu_tab[0]  = '{8'h55, 8'h00, OP_DIV,  8'hFF};
      alu_tab[1]  = '{8'h80, 8'h00, OP_ROL,  8'h01};
      alu_tab[2]  = '{8'h01, 8'hFF, OP_ADD,  8'h00};
      alu_tab[3]  = '{8'h02, 8'hFE, OP_SUB,  8'h04};
      alu_tab[4]  = '{8'h10, 8'h10, OP_MUL,  8'h00};
      alu_tab[5]  = '{8'hC8, 8'h03, OP_DIV,  8'h42};
      alu_tab[6]  = '{8'h81, 8'h00, OP_ROR,  8'hC0};
      alu_tab[7]  = '{8'h81, 8'h00, OP_SHL,  8'h02};
      alu_tab[8]  = '{8'h81, 8'h00, OP_SHR,  8'h40};
      alu_tab[9]  = '{8'hF0, 8'h3C, OP_NOR,  8'h03};
      alu_tab[10] = '{8'hF0, 8'h3C, OP_NAND, 8'hCF};
      alu_tab[11] = '{8'hF0, 8'h3C, OP_XNOR, 8'h33};
      alu_tab[12] = '{8'h05, 8'h04, OP_GT,   8'h01};
      alu_tab[13] = '{8'h04, 8'h05, OP_GT,   8'h00};
      alu_tab[14] = '{8'h07, 8'h07, OP_EQ,   8'h01};

      foreach (alu_tab[i])
         check($sformatf("alu_tab[%0d] op%0h", i, alu_tab[i].op),
               {24'h0, alu_fn(alu_tab[i].a, alu_tab[i].b, alu_tab[i].op)},
               {24'h0, alu_tab[i].r});

      repeat (2) @(negedge clk);
      #1 check_reset("por");
      reset = 1'b0;
      #1;
      run(-1, "run1");

      @(negedge clk);
      reset = 1'b1;
      #1 check_reset("post-run");
      @(negedge clk);
      reset = 1'b0;
      #1;
      run(100, "abort100");
      run(-1, "rerun");

      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         reset = 1'b1;
         @(negedge clk);
         reset = 1'b0;
         #1;
         run($urandom_range(1, 254), $sformatf("rnd%0d", k));
      end
      run(-1, "final");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
